// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  // Parity sense selectors for the PARITY_ODD parameter
  localparam int unsigned PARITY_EVEN    = 0;
  localparam int unsigned PARITY_ODD_SEL = 1;

  // 50 MHz system clock at 115200 baud
  localparam int unsigned CLKS_PER_BIT_115200 = 434;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser for asynchronous inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; reset value matches the idle level of the input
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver: synchronised input, mid-bit sampling, glitch rejection,
// framing check, optional parity check (enabled by UART_RX_PARITY_EN).
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = PARITY_EVEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rxd,
  output logic                 data_valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

`ifdef UART_RX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + STOP_BITS + 2);

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] FRAME_LAST = IDX_W'(DATA_BITS + PAR_BITS + STOP_BITS - 1);

  logic                 w_rxd_s;
  logic                 w_tick;
  logic                 w_stop_bad;
  rx_state_e            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr_acc;
  logic                 r_valid;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_ferr;
  logic                 r_busy;

`ifdef UART_RX_PARITY_EN
  logic r_perr_acc;
  logic r_perr;
  logic w_par_sel;
  assign w_par_sel = 1'(PARITY_ODD);
`else
  logic w_unused_par;
  assign w_unused_par = 1'(PARITY_ODD);
`endif

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (uart_rxd),
    .o_q (w_rxd_s)
  );

  assign w_tick     = (r_cnt == BIT_LAST);
  assign w_stop_bad = r_ferr_acc | ~w_rxd_s;

  // Receiver FSM: bit timing, shift register, error accumulation, result load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_ferr_acc <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_acc <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      // Strobe and error flags live for a single cycle
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (!w_rxd_s) begin
            r_state    <= START;
            r_busy     <= 1'b1;
            r_ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr_acc <= 1'b0;
`endif
          end
        end

        START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (!w_rxd_s) begin
              r_state <= DATA;
            end else begin
              // Line went back high before mid-bit: treat as noise
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_idx   <= r_idx + IDX_W'(1);
            r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
            if (r_idx == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (w_tick) begin
            r_cnt   <= '0;
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= STOP;
            if (w_rxd_s != ((^r_shift) ^ w_par_sel)) begin
              r_perr_acc <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`else
          r_state <= IDLE;
          r_busy  <= 1'b0;
`endif
        end

        STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            r_idx <= r_idx + IDX_W'(1);
            if (!w_rxd_s) begin
              r_ferr_acc <= 1'b1;
            end
            if (r_idx == FRAME_LAST) begin
              r_valid <= 1'b1;
              r_data  <= r_shift;
              r_ferr  <= w_stop_bad;
`ifdef UART_RX_PARITY_EN
              r_perr  <= r_perr_acc;
`endif
              // A low stop bit may be a break; wait for idle before rearming
              if (w_stop_bad) begin
                r_state <= WAIT_HIGH;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        WAIT_HIGH: begin
          if (w_rxd_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_valid = r_valid;
  assign data       = r_data;
  assign frame_err  = r_ferr;
  assign rx_busy    = r_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: an 8N1 instance and a 7-data/2-stop
// instance, both at 16 clocks per bit. Parity cases need UART_RX_PARITY_EN.
module tb_uart_rx_ext;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif

  logic       clk;
  logic       rst;
  logic       rxd8;
  logic       rxd7;
  logic       dv8, fe8, pe8, busy8;
  logic [7:0] d8;
  logic       dv7, fe7, pe7, busy7;
  logic [6:0] d7;

  int unsigned n_vec;
  int unsigned n_bad;
  int unsigned cyc;

  int unsigned n_dv8;
  logic [7:0]  dv8_data;
  logic        dv8_ferr;
  logic        dv8_perr;
  int unsigned dv8_cyc;
  int unsigned n_dv7;
  logic [6:0]  hist7 [0:3];
  logic        ferr7 [0:3];
  int unsigned n_flag_viol;

`ifdef UART_RX_PARITY_EN
  logic par_flip;
`endif

  uart_rx_ext #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .STOP_BITS    (1),
    .PARITY_ODD   (0)
  ) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .uart_rxd   (rxd8),
    .data_valid (dv8),
    .data       (d8),
    .frame_err  (fe8),
    .parity_err (pe8),
    .rx_busy    (busy8)
  );

  uart_rx_ext #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (7),
    .STOP_BITS    (2),
    .PARITY_ODD   (0)
  ) u_dut7 (
    .clk        (clk),
    .rst        (rst),
    .uart_rxd   (rxd7),
    .data_valid (dv7),
    .data       (d7),
    .frame_err  (fe7),
    .parity_err (pe7),
    .rx_busy    (busy7)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count for latency measurement
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitors, sampled on the inactive edge
  initial begin
    n_dv8 = 0;
    n_dv7 = 0;
    n_flag_viol = 0;
  end
  always @(negedge clk) begin
    if (dv8) begin
      n_dv8    <= n_dv8 + 1;
      dv8_data <= d8;
      dv8_ferr <= fe8;
      dv8_perr <= pe8;
      dv8_cyc  <= cyc;
    end else if (fe8 || pe8) begin
      n_flag_viol <= n_flag_viol + 1;
    end
    if (dv7) begin
      n_dv7            <= n_dv7 + 1;
      hist7[n_dv7 % 4] <= d7;
      ferr7[n_dv7 % 4] <= fe7;
    end else if (fe7 || pe7) begin
      n_flag_viol <= n_flag_viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int unsigned which, input logic v);
    if (which == 8) rxd8 = v;
    else            rxd7 = v;
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame, LSB first; line left at the last stop-bit level
  task automatic send_frame(input int unsigned which, input logic [8:0] d,
                            input int unsigned nbits, input logic stop1,
                            input logic stop2, input int unsigned nstop);
`ifdef UART_RX_PARITY_EN
    logic p;
    p = 1'b0;
    for (int i = 0; i < int'(nbits); i++) p = p ^ d[i];
`endif
    set_line(which, 1'b0);
    wait_cycles(CPB);
    for (int i = 0; i < int'(nbits); i++) begin
      set_line(which, d[i]);
      wait_cycles(CPB);
    end
`ifdef UART_RX_PARITY_EN
    set_line(which, p ^ par_flip);
    wait_cycles(CPB);
`endif
    set_line(which, stop1);
    wait_cycles(CPB);
    if (nstop == 2) begin
      set_line(which, stop2);
      wait_cycles(CPB);
    end
  endtask

  initial begin
    int unsigned t_start;
    int unsigned lat;
    int unsigned nb;
    int unsigned cnt_save;
    int unsigned exp_lat;

    n_vec = 0;
    n_bad = 0;
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    rst  = 1'b1;
    rxd8 = 1'b1;
    rxd7 = 1'b1;
    wait_cycles(3);

    // Reset state
    check("rst_valid8", 32'(dv8), 0);
    check("rst_data8",  32'(d8), 0);
    check("rst_ferr8",  32'(fe8), 0);
    check("rst_perr8",  32'(pe8), 0);
    check("rst_busy8",  32'(busy8), 0);
    check("rst_data7",  32'(d7), 0);
    check("rst_busy7",  32'(busy7), 0);
    rst = 1'b0;
    wait_cycles(5);

    // 8N1 frame 0xA5 with latency check
    exp_lat = 3 + CPB / 2 + (8 + PB + 1) * CPB;
    t_start = cyc;
    send_frame(8, 9'h0A5, 8, 1'b1, 1'b1, 1);
    wait_cycles(8);
    lat = dv8_cyc - t_start;
    check("a5_count", n_dv8, 1);
    check("a5_data",  32'(dv8_data), 32'h0A5);
    check("a5_ferr",  32'(dv8_ferr), 0);
    check("a5_perr",  32'(dv8_perr), 0);
    check("a5_busy_after", 32'(busy8), 0);
    check("a5_latency", (lat + 1 >= exp_lat && lat <= exp_lat + 1) ? exp_lat : lat, exp_lat);

    // Start-bit glitch: 4 low cycles
    nb = 0;
    rxd8 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) rxd8 = 1'b1;
      @(negedge clk);
      if (busy8) nb = nb + 1;
    end
    check("glitch_count", n_dv8, 1);
    check("glitch_busy_seen", 32'(nb >= 1), 1);
    check("glitch_busy_le9", 32'(nb <= 9), 1);
    check("glitch_busy_end", 32'(busy8), 0);
    check("glitch_data_held", 32'(d8), 32'h0A5);

    // Low stop bit then line held low: one strobe, then wait for idle
    send_frame(8, 9'h03C, 8, 1'b0, 1'b0, 1);
    wait_cycles(40);
    check("brk_count", n_dv8, 2);
    check("brk_data",  32'(dv8_data), 32'h03C);
    check("brk_ferr",  32'(dv8_ferr), 1);
    check("brk_busy_low_line", 32'(busy8), 1);
    rxd8 = 1'b1;
    wait_cycles(20);
    check("brk_busy_released", 32'(busy8), 0);
    send_frame(8, 9'h081, 8, 1'b1, 1'b1, 1);
    wait_cycles(8);
    check("post_brk_count", n_dv8, 3);
    check("post_brk_data",  32'(dv8_data), 32'h081);
    check("post_brk_ferr",  32'(dv8_ferr), 0);

`ifdef UART_RX_PARITY_EN
    // Even parity, 0x07: wrong then right parity bit
    par_flip = 1'b1;
    send_frame(8, 9'h007, 8, 1'b1, 1'b1, 1);
    wait_cycles(8);
    check("par_bad_data", 32'(dv8_data), 32'h007);
    check("par_bad_perr", 32'(dv8_perr), 1);
    par_flip = 1'b0;
    send_frame(8, 9'h007, 8, 1'b1, 1'b1, 1);
    wait_cycles(8);
    check("par_ok_perr", 32'(dv8_perr), 0);
    check("par_ok_ferr", 32'(dv8_ferr), 0);
`endif

    // 7 data bits, 2 stop bits, back-to-back
    send_frame(7, 9'h055, 7, 1'b1, 1'b1, 2);
    send_frame(7, 9'h02A, 7, 1'b1, 1'b1, 2);
    wait_cycles(8);
    check("b2b_count", n_dv7, 2);
    check("b2b_data0", 32'(hist7[0]), 32'h55);
    check("b2b_data1", 32'(hist7[1]), 32'h2A);
    check("b2b_ferr1", 32'(ferr7[1]), 0);
    send_frame(7, 9'h011, 7, 1'b1, 1'b0, 2);
    rxd7 = 1'b1;
    wait_cycles(8);
    check("stop2_count", n_dv7, 3);
    check("stop2_data",  32'(hist7[2]), 32'h11);
    check("stop2_ferr",  32'(ferr7[2]), 1);
    check("stop2_idle",  32'(busy7), 0);

    // Reset during data bit 3 of 0x96
    cnt_save = n_dv8;
    rxd8 = 1'b0;
    wait_cycles(CPB);
    rxd8 = 1'b0; wait_cycles(CPB);
    rxd8 = 1'b1; wait_cycles(CPB);
    rxd8 = 1'b1; wait_cycles(CPB);
    rxd8 = 1'b0; wait_cycles(CPB / 2);
    check("mid_busy", 32'(busy8), 1);
    rst  = 1'b1;
    rxd8 = 1'b1;
    @(negedge clk);
    check("mrst_valid", 32'(dv8), 0);
    check("mrst_data",  32'(d8), 0);
    check("mrst_ferr",  32'(fe8), 0);
    check("mrst_perr",  32'(pe8), 0);
    check("mrst_busy",  32'(busy8), 0);
    rst = 1'b0;
    wait_cycles(200);
    check("mrst_no_strobe", n_dv8, cnt_save);
    send_frame(8, 9'h0FF, 8, 1'b1, 1'b1, 1);
    wait_cycles(8);
    check("ff_count", n_dv8, cnt_save + 1);
    check("ff_data",  32'(dv8_data), 32'h0FF);
    check("ff_ferr",  32'(dv8_ferr), 0);

    check("flags_qualified", n_flag_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver for the serial console path: 2-flop input synchroniser, configurable bit period, data width and stop-bit count, start-bit glitch rejection, framing-error detection and optional parity checking. It drives the byte-level consumers that take a one-cycle `data_valid` strobe. It handles 5–9 data bits, LSB first, at any baud rate an integer `CLKS_PER_BIT` can express.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per bit (50 MHz / 115200); legal range ≥ 4.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `STOP_BITS`, 1: stop bits checked; legal values 1 or 2.
- `PARITY_ODD`, 0: 0 = even, 1 = odd; only used with `UART_RX_PARITY_EN`.

Ports:
- `clk`  in  1  system clock; the block has a single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `uart_rxd`  in  1  asynchronous serial line; idles high.
- `data_valid`  out  1  one-cycle strobe; frame complete.
- `data`  out  DATA_BITS  received word; holds its value until the next `data_valid`.
- `frame_err`  out  1  a stop bit sampled low; qualified by `data_valid`.
- `parity_err`  out  1  parity mismatch; qualified by `data_valid`.
- `rx_busy`  out  1  high whenever the state is not IDLE.

## Operation
- `uart_rxd` passes through a 2-flop synchroniser (reset value 1) to give `rxd_s`. All decisions use `rxd_s`.
- Counter width is `$clog2(CLKS_PER_BIT)`. The bit index counts to DATA_BITS+STOP_BITS (+1 with parity). The shift register is DATA_BITS wide and fills LSB first.
- States:
  - IDLE: `rxd_s`=0 → START, counter cleared.
  - START: at the mid-bit point, `rxd_s`=0 → DATA; `rxd_s`=1 → IDLE (glitch; no strobe, no error).
  - DATA: samples one bit per period. After DATA_BITS samples → PARITY if compiled in, else STOP.
  - PARITY: samples one bit and compares it against XOR(data) ^ PARITY_ODD. A mismatch sets the parity flag.
  - STOP: samples STOP_BITS bits. Any low stop bit sets the frame flag. After the last sample: `data_valid`=1, `data` and both error flags are loaded together. Next state is IDLE if the frame flag is clear, WAIT_HIGH if it is set.
  - WAIT_HIGH: stays until `rxd_s`=1, then → IDLE. This prevents a break or stuck-low line from being taken as back-to-back start bits.
- A frame with errors still delivers its data word.
- Reset (any state, mid-frame included), effective next edge: state IDLE, counters 0, `data_valid` 0, `data` 0, `frame_err` 0, `parity_err` 0, `rx_busy` 0, sync flops 1. A partial frame is discarded without a strobe.

## Timing
- t0 is the first cycle IDLE sees `rxd_s`=0. This is 2–3 cycles after the pin edge (synchroniser).
- Start sample is at t0 + CLKS_PER_BIT/2 (integer division).
- Sample k (k=0 is data bit 0, continuing through parity and stop bits) is at t0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- `data_valid` is high for exactly the one cycle after the last stop sample. `rx_busy` falls in that same cycle, unless the next state is WAIT_HIGH.
- Frame length N = 1 + DATA_BITS + P + STOP_BITS, where P = 1 with parity and 0 without. A new start edge is accepted from the cycle after `data_valid`, so back-to-back frames at the nominal rate are received with no loss.
- `frame_err` and `parity_err` are 0 whenever `data_valid` is 0.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state is built and N includes the parity bit; `parity_err` reports mismatches using PARITY_ODD.
- `UART_RX_PARITY_EN` undefined: the PARITY state and its logic are omitted and `parity_err` is tied to 0. The port list is identical in both builds.

## Structure
- Package `uart_pkg`:
  - receiver state enum typedef (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - constants PARITY_EVEN=0 and PARITY_ODD_SEL=1;
  - default baud constant CLKS_PER_BIT_115200=434.
- Sub-module `sync_2ff`: generic single-bit two-flop synchroniser with parameter RESET_VAL (1 here), reusable by other async inputs.

## Test plan
Bench uses CLKS_PER_BIT=16; the checker tolerates ±1 cycle on the strobe.
- 8N1 frame 0xA5 → one `data_valid` pulse, `data`=0xA5, `frame_err`=0, `parity_err`=0, `rx_busy` low after the strobe.
- Line low for 4 cycles, then high → no `data_valid`; `rx_busy` high for ≤ 9 cycles, then IDLE.
- Byte 0x3C with stop bit low, line held low 40 more cycles → `data_valid` with `data`=0x3C and `frame_err`=1; no further strobe while low. Line then high and byte 0x81 sent → `data`=0x81, `frame_err`=0.
- With `UART_RX_PARITY_EN`, even parity, byte 0x07 → parity bit 0 gives `parity_err`=1; parity bit 1 gives `parity_err`=0.
- DATA_BITS=7, STOP_BITS=2, bytes 0x55 then 0x2A back-to-back → two strobes with `data`=7'h55 and `data`=7'h2A. A second stop bit sampled low → `frame_err`=1.
- `rst` pulsed during data bit 3 of 0x96 → no strobe, all outputs at reset values. Next frame 0xFF → `data`=0xFF.
